// File: rtl/divider_check_pkg.sv
// divider_check_pkg: shared state encoding and default widths for the divider result checker.
package divider_check_pkg;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;
endpackage

// File: rtl/shift_add_mul_step.sv
// shift_add_mul_step: one shift-add multiplier step, adds d<<iter when the current quotient bit is set.
module shift_add_mul_step #(
  parameter int DW = 8,
  parameter int IW = $clog2(DW)
) (
  input  logic [2*DW-1:0] prod_i,
  input  logic [DW-1:0]   d_i,
  input  logic            q_lsb_i,
  input  logic [IW-1:0]   iter_i,
  output logic [2*DW-1:0] prod_o
);
  always_comb prod_o = q_lsb_i ? prod_i + ((2*DW)'(d_i) << iter_i) : prod_i;
endmodule

// File: rtl/divider_result_reconstructor.sv
// divider_result_reconstructor: rebuilds q*d+r sequentially, reports |n-n_hat| and saturating error stats.
module divider_result_reconstructor
  import divider_check_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   n,
  input  logic [DW-1:0]     d,
  input  logic [DW-1:0]     q,
  input  logic [DW-1:0]     r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   n_hat,
  output logic [2*DW-1:0]   abs_err,
  input  logic              stat_clear,
  output logic [ACC_W-1:0]  err_sum,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int IW = $clog2(DW);
  state_t state_q, state_d;
  logic [2*DW-1:0] n_q, n_d, prod_q, prod_d, prod_nx, n_hat_q, n_hat_d, abs_err_q, abs_err_d, n_hat_c;
  logic [DW-1:0] d_q, d_d, q_q, q_d, r_q, r_d;
  logic [IW-1:0] iter_q, iter_d;
  logic ov_q, ov_d, accept, fire;
  logic [ACC_W-1:0] err_sum_q, err_sum_d, sum_base;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, cnt_base;
  logic [ACC_W:0] sum_c;
  logic [CNT_W:0] cnt_c;
  shift_add_mul_step #(.DW(DW), .IW(IW)) u_step (
    .prod_i (prod_q),
    .d_i    (d_q),
    .q_lsb_i(q_q[0]),
    .iter_i (iter_q),
    .prod_o (prod_nx)
  );
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    q_d       = q_q;
    r_d       = r_q;
    prod_d    = prod_q;
    iter_d    = iter_q;
    n_hat_d   = n_hat_q;
    abs_err_d = abs_err_q;
    ov_d      = ov_q;
    in_ready  = state_q == IDLE;
    accept    = in_valid & in_ready;
    fire      = ov_q & out_ready;
    n_hat_c   = prod_q + (2*DW)'(r_q);
    case (state_q)
      IDLE: if (accept) begin
        n_d     = n;
        d_d     = d;
        q_d     = q;
        r_d     = r;
        prod_d  = '0;
        iter_d  = '0;
        state_d = MUL;
      end
      MUL: begin
        prod_d  = prod_nx;
        q_d     = q_q >> 1;
        iter_d  = iter_q + 1'b1;
        state_d = iter_q == IW'(DW-1) ? ADD : MUL;
      end
      ADD: begin
        n_hat_d   = n_hat_c;
        abs_err_d = n_q >= n_hat_c ? n_q - n_hat_c : n_hat_c - n_q;
        state_d   = DONE;
      end
      DONE: begin
        ov_d    = !fire;
        state_d = fire ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
    // a clear coinciding with a handshake lets that result seed the fresh statistics
    sum_base  = stat_clear ? '0 : err_sum_q;
    cnt_base  = stat_clear ? '0 : err_cnt_q;
    sum_c     = {1'b0, sum_base} + (ACC_W+1)'(abs_err_q);
    cnt_c     = {1'b0, cnt_base} + (CNT_W+1)'(1);
    err_sum_d = !fire ? sum_base : sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
    err_cnt_d = !fire ? cnt_base : cnt_c[CNT_W] ? '1 : cnt_c[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      d_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      prod_q    <= '0;
      iter_q    <= '0;
      n_hat_q   <= '0;
      abs_err_q <= '0;
      ov_q      <= 1'b0;
      err_sum_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      d_q       <= d_d;
      q_q       <= q_d;
      r_q       <= r_d;
      prod_q    <= prod_d;
      iter_q    <= iter_d;
      n_hat_q   <= n_hat_d;
      abs_err_q <= abs_err_d;
      ov_q      <= ov_d;
      err_sum_q <= err_sum_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign out_valid = ov_q;
  assign n_hat     = n_hat_q;
  assign abs_err   = abs_err_q;
  assign err_sum   = err_sum_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_divider_result_reconstructor.sv
// tb_divider_result_reconstructor: directed and random transactions against an arithmetic reference model.
module tb_divider_result_reconstructor;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, stat_clear = 0;
  logic [15:0] n = 0;
  logic [7:0] d = 0, q = 0, r = 0;
  logic in_ready, out_valid, s_in_ready, s_out_valid;
  logic [15:0] n_hat, abs_err, s_n_hat, s_abs_err, err_cnt, s_err_cnt;
  logic [31:0] err_sum;
  logic [16:0] s_err_sum;
  int n_chk = 0, n_fail = 0;
  longint full_sum = 0, full_cnt = 0;
  always #5 clk = ~clk;
  divider_result_reconstructor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .n(n), .d(d), .q(q), .r(r),
    .out_valid(out_valid), .out_ready(out_ready), .n_hat(n_hat), .abs_err(abs_err),
    .stat_clear(stat_clear), .err_sum(err_sum), .err_cnt(err_cnt)
  );
  divider_result_reconstructor #(.ACC_W(17)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .n(n), .d(d), .q(q), .r(r),
    .out_valid(s_out_valid), .out_ready(out_ready), .n_hat(s_n_hat), .abs_err(s_abs_err),
    .stat_clear(stat_clear), .err_sum(s_err_sum), .err_cnt(s_err_cnt)
  );
  function automatic longint sat(input longint v, input longint m);
    return v > m ? m : v;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_stats();
    chk("err_sum", err_sum, sat(full_sum, 64'hFFFF_FFFF));
    chk("err_cnt", err_cnt, sat(full_cnt, 65535));
    chk("sat_err_sum", s_err_sum, sat(full_sum, 131071));
    chk("sat_err_cnt", s_err_cnt, sat(full_cnt, 65535));
  endtask
  task automatic xact(input int tn, input int td, input int tq, input int tr, input int hold, input bit clr);
    int en, ee, lat;
    en = tq * td + tr;
    ee = tn >= en ? tn - en : en - tn;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; n = 16'(tn); d = 8'(td); q = 8'(tq); r = 8'(tr);
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 10);
    chk("n_hat", n_hat, en);
    chk("abs_err", abs_err, ee);
    chk("sat_n_hat", s_n_hat, en);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; n = 16'($urandom); d = 8'($urandom); q = 8'($urandom); r = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_n_hat", n_hat, en);
      chk("hold_abs_err", abs_err, ee);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_err_cnt", err_cnt, sat(full_cnt, 65535));
    end
    in_valid = 0; out_ready = 1; stat_clear = clr;
    @(posedge clk); #1;
    out_ready = 0; stat_clear = 0;
    if (clr) begin full_sum = 0; full_cnt = 0; end
    full_sum += ee;
    full_cnt++;
    chk_stats();
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_n_hat", n_hat, 0);
    chk("rst_abs_err", abs_err, 0);
    chk_stats();
    rst = 0;
    xact(1000, 7, 142, 6, 0, 0);
    xact(1000, 7, 140, 6, 0, 0);
    xact(0, 255, 255, 255, 5, 0);
    xact(65535, 0, 9, 3, 0, 0);
    stat_clear = 1;
    @(posedge clk); #1;
    stat_clear = 0;
    full_sum = 0; full_cnt = 0;
    chk_stats();
    repeat (3) xact(0, 255, 255, 255, 0, 0);
    xact(0, 255, 255, 255, 0, 1);
    in_valid = 1; n = 16'd1000; d = 8'd7; q = 8'd142; r = 8'd6;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    full_sum = 0; full_cnt = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_n_hat", n_hat, 0);
    chk_stats();
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_result", out_valid, 0);
    xact(1000, 7, 142, 6, 0, 0);
    for (int i = 0; i < 30; i++)
      xact(int'($urandom_range(65535)), int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(255)), int'($urandom_range(3)), $urandom_range(4) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
